// File: rtl/count_ring_sequencer_if.sv
// Counter-sample interface between the upstream up-counter side and count_ring_sequencer.
// The master drives samples and err_clr; the slave returns the ring phase and error status.
interface count_ring_sequencer_if #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned RING_W   = 4,
  parameter int unsigned ERRCNT_W = 8
) ();
  logic [CNT_W-1:0]          count_in;
  logic                      count_valid;
  logic                      err_clr;
  logic [RING_W-1:0]         ring_out;
  logic [$clog2(RING_W)-1:0] phase_idx;
  logic                      wrap_pulse;
  logic                      seq_err;
  logic                      sticky_err;
  logic [ERRCNT_W-1:0]       err_count;
  logic                      in_sync;

  modport master (
    output count_in, count_valid, err_clr,
    input  ring_out, phase_idx, wrap_pulse, seq_err, sticky_err, err_count, in_sync
  );

  modport slave (
    input  count_in, count_valid, err_clr,
    output ring_out, phase_idx, wrap_pulse, seq_err, sticky_err, err_count, in_sync
  );
endinterface

// File: rtl/count_ring_sequencer.sv
// Tracks an up-counter stream, advances a one-hot ring on each wrap, flags sequence errors.
// Optional macro RING_DIR_EN adds a ring_dir input selecting right rotation / decrementing phase.
module count_ring_sequencer #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned RING_W   = 4,
  parameter int unsigned ERRCNT_W = 8
) (
  input logic clk,
  input logic reset,
`ifdef RING_DIR_EN
  input logic ring_dir,
`endif
  count_ring_sequencer_if.slave bus
);
  localparam int unsigned PhW = $clog2(RING_W);

  typedef enum logic [1:0] {StIdle, StTrack, StError} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    prev_q;
  logic [RING_W-1:0]   ring_q;
  logic [PhW-1:0]      phase_q;
  logic                wrap_q;
  logic                seq_err_q;
  logic                sticky_q;
  logic [ERRCNT_W-1:0] err_cnt_q;
  logic                in_sync_q;
  logic [1:0]          good_q;

  logic [CNT_W-1:0]    expected;
  logic                match;
  logic                wrap_det;
  logic                rot_right;
  logic [RING_W-1:0]   ring_next;
  logic [PhW-1:0]      phase_next;
  logic [ERRCNT_W-1:0] err_cnt_inc;

  always_comb begin
    expected = prev_q + CNT_W'(1);
    match    = (bus.count_in == expected);
    wrap_det = (prev_q == '1) && (bus.count_in == '0);
`ifdef RING_DIR_EN
    rot_right = ring_dir;
`else
    rot_right = 1'b0;
`endif
    if (rot_right) begin
      ring_next  = {ring_q[0], ring_q[RING_W-1:1]};
      phase_next = (phase_q == '0) ? PhW'(RING_W - 1) : phase_q - PhW'(1);
    end else begin
      ring_next  = {ring_q[RING_W-2:0], ring_q[RING_W-1]};
      phase_next = (phase_q == PhW'(RING_W - 1)) ? '0 : phase_q + PhW'(1);
    end
    // A mismatch in the same cycle as err_clr restarts the count at one.
    if (bus.err_clr)           err_cnt_inc = ERRCNT_W'(1);
    else if (err_cnt_q == '1)  err_cnt_inc = err_cnt_q;
    else                       err_cnt_inc = err_cnt_q + ERRCNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      ring_q    <= RING_W'(1);
      phase_q   <= '0;
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
      in_sync_q <= 1'b0;
      good_q    <= '0;
    end else begin
      wrap_q    <= 1'b0;
      seq_err_q <= 1'b0;
      if (bus.err_clr) begin
        sticky_q  <= 1'b0;
        err_cnt_q <= '0;
      end
      if (bus.count_valid) begin
        prev_q <= bus.count_in;
        unique case (state_q)
          StIdle: begin
            state_q   <= StTrack;
            in_sync_q <= 1'b1;
          end
          StTrack: begin
            if (match) begin
              if (wrap_det) begin
                wrap_q  <= 1'b1;
                ring_q  <= ring_next;
                phase_q <= phase_next;
              end
            end else begin
              seq_err_q <= 1'b1;
              sticky_q  <= 1'b1;
              err_cnt_q <= err_cnt_inc;
              state_q   <= StError;
              in_sync_q <= 1'b0;
              good_q    <= '0;
            end
          end
          StError: begin
            // Two consecutive good samples resync; the second is never a wrap.
            if (match) begin
              if (good_q == 2'd1) begin
                state_q   <= StTrack;
                in_sync_q <= 1'b1;
                good_q    <= '0;
              end else begin
                good_q <= good_q + 2'd1;
              end
            end else begin
              seq_err_q <= 1'b1;
              sticky_q  <= 1'b1;
              err_cnt_q <= err_cnt_inc;
              good_q    <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.ring_out   = ring_q;
  assign bus.phase_idx  = phase_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.sticky_err = sticky_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.in_sync    = in_sync_q;
endmodule

// File: tb/tb_count_ring_sequencer.sv
// Scoreboard bench for count_ring_sequencer: a behavioural model queues expected outputs per
// driven sample, compared one clock later.
module tb_count_ring_sequencer;
  logic clk;
  logic reset;
`ifdef RING_DIR_EN
  logic ring_dir;
`endif

  count_ring_sequencer_if #(.CNT_W(4), .RING_W(4), .ERRCNT_W(8)) bus ();

  count_ring_sequencer #(.CNT_W(4), .RING_W(4), .ERRCNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef RING_DIR_EN
    .ring_dir (ring_dir),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ring;
    logic [1:0] phase;
    logic       wrap;
    logic       serr;
    logic       sticky;
    logic [7:0] ecnt;
    logic       sync;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   wrap_seen = 0;

  // Reference model state: 0 idle, 1 track, 2 error.
  int m_state, m_prev, m_ring, m_phase, m_ecnt, m_good;
  bit m_sticky, m_sync;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_ring = 1; m_phase = 0; m_ecnt = 0; m_good = 0;
    m_sticky = 0; m_sync = 0;
    sb.delete();
  endtask

  task automatic model_step(input bit valid, input int val, input bit clr);
    exp_t e;
    bit   mm, wr;
    e.wrap = 0;
    e.serr = 0;
    if (clr) begin m_sticky = 0; m_ecnt = 0; end
    if (valid) begin
      mm = (val != ((m_prev + 1) % 16));
      wr = (m_prev == 15) && (val == 0);
      if (m_state == 0) begin
        m_state = 1; m_sync = 1;
      end else if (mm) begin
        e.serr = 1; m_sticky = 1;
        m_ecnt = (m_ecnt == 255) ? 255 : m_ecnt + 1;
        m_state = 2; m_sync = 0; m_good = 0;
      end else if (m_state == 1) begin
        if (wr) begin
          e.wrap  = 1;
          m_ring  = (m_ring == 8) ? 1 : m_ring * 2;
          m_phase = (m_phase + 1) % 4;
        end
      end else begin
        m_good++;
        if (m_good == 2) begin m_state = 1; m_sync = 1; m_good = 0; end
      end
      m_prev = val;
    end
    e.ring = 4'(m_ring); e.phase = 2'(m_phase); e.sticky = m_sticky;
    e.ecnt = 8'(m_ecnt); e.sync = m_sync;
    sb.push_back(e);
  endtask

  // Drive one cycle (called at posedge+1), then compare at the next posedge+1.
  task automatic drive(input bit valid, input int val, input bit clr);
    exp_t e;
    bus.count_valid = valid;
    bus.count_in    = 4'(val);
    bus.err_clr     = clr;
    model_step(valid, val, clr);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ring_out",   32'(bus.ring_out),   32'(e.ring));
      check("phase_idx",  32'(bus.phase_idx),  32'(e.phase));
      check("wrap_pulse", 32'(bus.wrap_pulse), 32'(e.wrap));
      check("seq_err",    32'(bus.seq_err),    32'(e.serr));
      check("sticky_err", 32'(bus.sticky_err), 32'(e.sticky));
      check("err_count",  32'(bus.err_count),  32'(e.ecnt));
      check("in_sync",    32'(bus.in_sync),    32'(e.sync));
    end
    if (bus.wrap_pulse === 1'b1) wrap_seen++;
  endtask

  task automatic feed(input int v);
    drive(1'b1, v, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    bus.count_in = '0; bus.count_valid = 1'b0; bus.err_clr = 1'b0;
`ifdef RING_DIR_EN
    ring_dir = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ring",   32'(bus.ring_out),   32'h1);
    check("rst_phase",  32'(bus.phase_idx),  32'h0);
    check("rst_wrap",   32'(bus.wrap_pulse), 32'h0);
    check("rst_serr",   32'(bus.seq_err),    32'h0);
    check("rst_sticky", 32'(bus.sticky_err), 32'h0);
    check("rst_ecnt",   32'(bus.err_count),  32'h0);
    check("rst_sync",   32'(bus.in_sync),    32'h0);
    reset = 1'b1;

    // First run 0..15,0: exactly one wrap, ring 0001 -> 0010.
    for (int i = 0; i < 16; i++) feed(i);
    check("sync_after_first", 32'(bus.in_sync), 32'h1);
    feed(0);
    check("wrap_count_1", 32'(wrap_seen), 32'd1);
    check("ring_after_wrap1", 32'(bus.ring_out), 32'h2);

    // Three more wraps: ring returns to 0001, phase 3 -> 0.
    for (int w = 0; w < 3; w++) begin
      for (int i = 1; i < 16; i++) feed(i);
      feed(0);
    end
    check("wrap_count_4", 32'(wrap_seen), 32'd4);
    check("ring_after_wrap4", 32'(bus.ring_out), 32'h1);

    // Skip 5 -> 7, then 8,9 resync.
    for (int i = 1; i <= 5; i++) feed(i);
    feed(7);
    feed(8);
    feed(9);
    check("resync_after_9", 32'(bus.in_sync), 32'h1);

    // Stall 3,3 then 4,5 resync; later err_clr with a 15->1 mismatch.
    feed(3); feed(3); feed(4); feed(5);
    for (int i = 6; i < 16; i++) feed(i);
    drive(1'b1, 1, 1'b1);
    check("clr_vs_err_cnt", 32'(bus.err_count), 32'h1);
    feed(2); feed(3);

    // Valid gaps before a wrap, with a lone err_clr inside the gap.
    for (int i = 4; i < 16; i++) feed(i);
    drive(1'b0, 9, 1'b0);
    drive(1'b0, 2, 1'b1);
    drive(1'b0, 7, 1'b0);
    feed(0);
    check("gap_wrap_ring", 32'(bus.ring_out), 32'h4 >> 1);

    // Saturate err_count with repeated stalls.
    for (int i = 0; i < 260; i++) feed(5);
    check("ecnt_saturated", 32'(bus.err_count), 32'hff);

    // Recover and wrap again so ring sits at 0100.
    drive(1'b1, 6, 1'b1);
    feed(7);
    for (int i = 8; i < 16; i++) feed(i);
    feed(0);
    feed(1);
    check("ring_before_rst", 32'(bus.ring_out), 32'h4);

    // Asynchronous reset away from the clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_ring", 32'(bus.ring_out),  32'h1);
    check("async_ecnt", 32'(bus.err_count), 32'h0);
    check("async_sync", 32'(bus.in_sync),   32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    feed(9);
    feed(10);
    feed(12);
    feed(13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/count_ring_sequencer.md
Name: count_ring_sequencer

Overview:
- Downstream consumer of the 4-bit binary up-counter output in the counter subsystem.
- Samples the counter value each valid cycle, detects wrap (all-ones to zero), and advances a one-hot ring phase on every wrap.
- Checks that successive samples increment by exactly 1 (mod 2^CNT_W); flags skips and stalls, freezes the ring, and resynchronises automatically.

Parameters:
- CNT_W, 4, width of the incoming counter value.
- RING_W, 4, number of one-hot ring phases (>=2).
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- count_in  input  CNT_W  counter value from upstream binary up-counter
- count_valid  input  1  count_in is valid this cycle
- err_clr  input  1  clears sticky_err and err_count
- ring_out  output  RING_W  one-hot ring phase
- phase_idx  output  $clog2(RING_W)  binary index of the active ring bit
- wrap_pulse  output  1  one-cycle pulse on detected wrap
- seq_err  output  1  one-cycle pulse on sequence mismatch
- sticky_err  output  1  set on any mismatch, held until err_clr
- err_count  output  ERRCNT_W  saturating mismatch count
- in_sync  output  1  high while FSM is in TRACK

Behaviour:
- Reset (reset=0, async): ring_out = 1 (bit 0), phase_idx = 0, wrap_pulse = 0, seq_err = 0, sticky_err = 0, err_count = 0, in_sync = 0, prev register = 0, FSM = IDLE, good-run counter = 0.
- Reset is asynchronous on assertion; all outputs take reset values immediately, even mid-operation. Deassertion is sampled on clk.
- All outputs are registered. Latency from a count_valid sample to its wrap_pulse, seq_err or ring update is 1 clk.
- Cycles with count_valid=0 change nothing except err_clr handling; prev is held.
- expected = prev + 1, truncated to CNT_W bits, so all-ones+1 = 0.
- Wrap is detected when prev = all-ones and count_in = 0.
- FSM state IDLE:
  - On the first valid sample, capture prev = count_in, perform no check, go to TRACK.
- FSM state TRACK:
  - Valid sample with count_in == expected: update prev. If this is a wrap, pulse wrap_pulse, rotate ring_out left by one (MSB wraps to bit 0), and set phase_idx = (phase_idx+1) mod RING_W.
  - Valid sample with count_in != expected: pulse seq_err, set sticky_err, increment err_count (saturating at all-ones), capture prev = count_in, go to ERROR. No wrap_pulse and no ring move on a mismatching sample.
- FSM state ERROR:
  - Ring is frozen and wrap_pulse is suppressed.
  - Each valid sample equal to expected increments the good-run counter; a mismatch clears it and pulses seq_err/err_count again.
  - prev is always updated.
  - When the good-run counter reaches 2, return to TRACK and clear the counter. The sample that completes resync is not treated as a wrap even if it is all-ones->0.
- in_sync = 1 only in TRACK.
- err_clr: on the next edge, clear sticky_err and err_count. If a mismatch occurs in the same cycle, the error wins: sticky_err = 1 and err_count = 1.
- err_count saturation: at all-ones it stays all-ones; seq_err still pulses.
- Repeated value (stall with count_valid=1) is a mismatch.

Optional Feature:
- Macro RING_DIR_EN.
- Defined: adds input port ring_dir (1 bit). ring_dir=0 rotates left and increments phase_idx. ring_dir=1 rotates right (bit 0 wraps to MSB) and decrements phase_idx mod RING_W. ring_dir is sampled in the same cycle as the wrapping sample.
- Undefined: port absent; rotation is always left.

Test Plan:
- Reset then a valid sequence 0,1,...,15,0 -> in_sync=1 after the first sample; wrap_pulse exactly once, 1 clk after the 0 sample; ring_out 0001->0010, phase_idx 0->1.
- Four full wraps of 0..15 -> ring_out 0001,0010,0100,1000,0001 and phase_idx wraps 3->0.
- In TRACK, feed 5 then 7 -> seq_err pulses 1 clk, sticky_err=1, err_count=1, in_sync=0. Then 8,9 -> in_sync=1 after the 9 sample; ring unchanged throughout.
- Stall: 3,3 valid -> seq_err. Then 4,5 -> resync. Later 14,15 and err_clr asserted with a 15->1 mismatch in the same cycle -> sticky_err=1, err_count=1.
- count_valid gaps: 15, idle 3 cycles, 0 -> wrap_pulse still fires; no error.
- Assert reset low mid-sequence with ring_out=0100 -> immediate ring_out=0001, err_count=0, FSM in IDLE. First post-reset sample is not checked.
